// File: rtl/lvt_pkg.sv
// Shared definitions for the live-value-table multiported RAM and its read-side front end.
package lvt_pkg;

  localparam int unsigned LvtAddrWidth = 14;
  localparam int unsigned LvtDataWidth = 32;

  typedef logic [LvtAddrWidth-1:0] addr_t;
  typedef logic [LvtDataWidth-1:0] data_t;

endpackage

// File: rtl/lvt_resp_fifo.sv
// Small in-order response FIFO; power-of-two depth so pointers wrap naturally.
module lvt_resp_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CntW-1:0]       count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q < CntW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));

endmodule

// File: rtl/lvt_read_port.sv
// Read-side front end of the 2W/1R LVT RAM: credit-checked issue, one-cycle capture,
// in-order return through a response FIFO.
module lvt_read_port
  import lvt_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LvtAddrWidth,
  parameter int unsigned DATA_WIDTH = LvtDataWidth,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  mem_wr_busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  idle
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic            inflight_q, inflight_d;
  logic [CntW-1:0] fifo_count;
  logic [CntW-1:0] occupancy;
  logic            fifo_empty;
  logic            fire;
  logic            pop;
  logic            credit_ok;

  assign resp_valid = !fifo_empty;
  assign pop        = resp_valid & resp_ready;
  assign occupancy  = fifo_count + CntW'(inflight_q);

  // A same-cycle pop frees a slot, so a full FIFO can still accept under drain.
  assign credit_ok  = (occupancy < CntW'(FIFO_DEPTH)) | pop;

  // RAM banks drop reads during write cycles, so issue waits out any write.
  always_comb begin
    req_ready   = rst_n & !mem_wr_busy & credit_ok;
    fire        = req_valid & req_ready;
    mem_rd_en   = fire;
    mem_rd_addr = req_addr;
    inflight_d  = fire;
    idle        = (occupancy == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  lvt_resp_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .pop      (pop),
    .data_in  (mem_rd_data),
    .data_out (resp_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_lvt_read_port.sv
// Bench for lvt_read_port: RAM model, queue-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_lvt_read_port;
  import lvt_pkg::*;

  localparam int unsigned Depth = 2;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  req_valid, req_ready;
  addr_t req_addr;
  logic  resp_valid, resp_ready;
  data_t resp_data;
  logic  mem_wr_busy;
  logic  mem_rd_en;
  addr_t mem_rd_addr;
  data_t mem_rd_data;
  logic  idle;

  addr_t wr_addr;
  data_t wr_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    data_t data;
    int    avail;
  } ent_t;

  ent_t  q[$];
  data_t got_q[$];
  data_t wmem[int];

  lvt_read_port #(
    .ADDR_WIDTH (LvtAddrWidth),
    .DATA_WIDTH (LvtDataWidth),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .mem_wr_busy (mem_wr_busy),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t rd(input addr_t a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    if (a == 14'h0005) return 32'hDEADBEEF;
    return 32'hA000_0000 | data_t'(a);
  endfunction

  // RAM model: registered read, writes land at the end of busy cycles.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rd(mem_rd_addr);
    if (mem_wr_busy) wmem[int'(wr_addr)] = wr_data;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: every accepted read is owed one response, visible two cycles after issue.
  always @(negedge clk) begin
    logic  exp_rv, exp_rr, pop_m, fire_m;
    if (!rst_n) begin
      q.delete();
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_rd_en", mem_rd_en, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_idle", idle, 1);
    end else begin
      exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
      pop_m  = exp_rv && resp_ready;
      exp_rr = !mem_wr_busy && ((q.size() < Depth) || pop_m);
      fire_m = req_valid && exp_rr;
      check("m_resp_valid", resp_valid, exp_rv);
      check("m_req_ready", req_ready, exp_rr);
      check("m_mem_rd_en", mem_rd_en, fire_m);
      check("m_idle", idle, q.size() == 0);
      if (exp_rv) check("m_resp_data", resp_data, q[0].data);
      if (fire_m) check("m_mem_rd_addr", mem_rd_addr, req_addr);
      if (pop_m) begin
        got_q.push_back(resp_data);
        void'(q.pop_front());
      end
      if (fire_m) q.push_back('{data: rd(req_addr), avail: cyc + 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int fires;
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 14'h0005; resp_ready = 1'b0;
    mem_wr_busy = 1'b0; wr_addr = '0; wr_data = '0;

    // 1. Reset with a pending request, then release
    tick(); tick(); settle();
    check("t1_req_ready", req_ready, 0);
    check("t1_mem_rd_en", mem_rd_en, 0);
    check("t1_resp_valid", resp_valid, 0);
    check("t1_idle", idle, 1);

    // 2. Single read of 0x0005
    tick(); rst_n = 1'b1; resp_ready = 1'b1; settle();
    check("t2_req_ready", req_ready, 1);
    check("t2_mem_rd_en", mem_rd_en, 1);
    check("t2_mem_rd_addr", mem_rd_addr, 14'h0005);
    tick(); req_valid = 1'b0; settle();
    check("t2_n1_resp_valid", resp_valid, 0);
    check("t2_n1_idle", idle, 0);
    tick(); settle();
    check("t2_n2_resp_valid", resp_valid, 1);
    check("t2_n2_resp_data", resp_data, 32'hDEADBEEF);
    tick(); settle();
    check("t2_idle_after_pop", idle, 1);

    // 3. Streaming four reads
    got_q.delete();
    for (int i = 1; i <= 4; i++) begin
      tick(); req_valid = 1'b1; req_addr = addr_t'(i); settle();
      check("t3_req_ready", req_ready, 1);
    end
    tick(); req_valid = 1'b0;
    repeat (4) tick();
    check("t3_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t3_d0", got_q[0], 32'hA0000001);
      check("t3_d1", got_q[1], 32'hA0000002);
      check("t3_d2", got_q[2], 32'hA0000003);
      check("t3_d3", got_q[3], 32'hA0000004);
    end

    // 4. Backpressure
    got_q.delete();
    resp_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); req_valid = 1'b1; req_addr = addr_t'(14'h0020 + fires); settle();
      if (req_ready) fires++;
    end
    check("t4_fires", fires, 2);
    check("t4_blocked", req_ready, 0);
    tick(); resp_ready = 1'b1; req_addr = 14'h0022; settle();
    check("t4_ready_same_cycle", req_ready, 1);
    tick(); req_valid = 1'b0;
    repeat (5) tick();
    check("t4_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t4_d0", got_q[0], 32'hA0000020);
      check("t4_d1", got_q[1], 32'hA0000021);
      check("t4_d2", got_q[2], 32'hA0000022);
    end

    // 5. Write collision on 0x0010
    got_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_wr_busy = 1'b1; wr_addr = 14'h0010; wr_data = 32'h1111_1111 * data_t'(k + 1);
      req_valid = 1'b1; req_addr = 14'h0010; settle();
      check("t5_busy_ready", req_ready, 0);
      check("t5_busy_rd_en", mem_rd_en, 0);
    end
    tick(); mem_wr_busy = 1'b0; settle();
    check("t5_fire", req_ready, 1);
    tick(); req_valid = 1'b0;
    repeat (4) tick();
    check("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t5_data", got_q[0], 32'h33333333);

    // 6. Reset with one read in flight and one buffered
    got_q.delete();
    resp_ready = 1'b0;
    tick(); req_valid = 1'b1; req_addr = 14'h0030;
    tick(); req_addr = 14'h0031;
    tick(); req_valid = 1'b0; settle();
    check("t6_busy_before_rst", idle, 0);
    rst_n = 1'b0; settle();
    check("t6_rst_resp_valid", resp_valid, 0);
    check("t6_rst_idle", idle, 1);
    tick(); rst_n = 1'b1; resp_ready = 1'b1;
    repeat (4) tick();
    check("t6_no_stale", got_q.size(), 0);
    req_valid = 1'b1; req_addr = 14'h0005;
    tick(); req_valid = 1'b0;
    repeat (4) tick();
    check("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t6_data", got_q[0], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
